// File: rtl/sram_pkg.sv
// Shared definitions for the Ram1 SRAM port responder: state encoding and
// default geometry/timing constants.
package sram_pkg;

  localparam int ADDR_W_DEF       = 18;
  localparam int DATA_W_DEF       = 16;
  localparam int WR_PULSE_CYC_DEF = 2;
  localparam int RD_WAIT_CYC_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_PULSE = 3'd2,
    WR_HOLD  = 3'd3,
    RD_WAIT  = 3'd4,
    VR_WAIT  = 3'd5
  } sram_state_e;

endpackage

// File: rtl/sram_port_responder_if.sv
// Request-side handshake between a bus-master controller and the SRAM responder.
interface sram_port_responder_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              verify_err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, busy, verify_err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, busy, verify_err
  );

endinterface

// File: rtl/sram_port_responder.sv
// Single-word read/write responder driving the asynchronous Ram1 SRAM pins.
// Define SRAM_WRITE_VERIFY_EN to read back every write and flag mismatches.
module sram_port_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WR_PULSE_CYC = WR_PULSE_CYC_DEF,
  parameter int RD_WAIT_CYC  = RD_WAIT_CYC_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  sram_port_responder_if.slave  bus,
  output logic [ADDR_W-1:0]     Ram1Addr,
  inout  wire  [DATA_W-1:0]     Ram1Data,
  output logic                  Ram1OE,
  output logic                  Ram1WE,
  output logic                  Ram1EN
);

  localparam int MAX_CYC = (WR_PULSE_CYC > RD_WAIT_CYC) ? WR_PULSE_CYC : RD_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT_CYC - 1);

  sram_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              drive_en;
  logic              ack_q;
  logic              busy_q;
`ifdef SRAM_WRITE_VERIFY_EN
  logic              verify_err_q;
`endif

  // The bus is only driven during the write phases; reset clears drive_en
  // asynchronously so the pins release the moment RST falls.
  assign Ram1Data   = drive_en ? wdata_q : 'z;
  assign bus.ack    = ack_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
`ifdef SRAM_WRITE_VERIFY_EN
  assign bus.verify_err = verify_err_q;
`else
  assign bus.verify_err = 1'b0;
`endif

  // NOTE: all state and pin registers use non-blocking assignments so every
  // branch sees the pre-edge values and the pins change together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      drive_en <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      Ram1Addr <= '0;
      Ram1OE   <= 1'b1;
      Ram1WE   <= 1'b1;
      Ram1EN   <= 1'b1;
`ifdef SRAM_WRITE_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.req) begin
            busy_q   <= 1'b1;
            cnt      <= '0;
            Ram1Addr <= bus.addr;
            wdata_q  <= bus.wdata;
            Ram1EN   <= 1'b0;
            if (bus.we) begin
              state    <= WR_SETUP;
              drive_en <= 1'b1;
            end else begin
              state  <= RD_WAIT;
              Ram1OE <= 1'b0;
            end
          end
        end
        WR_SETUP: begin
          state  <= WR_PULSE;
          Ram1WE <= 1'b0;
          cnt    <= '0;
        end
        WR_PULSE: begin
          if (cnt == WR_LAST) begin
            state  <= WR_HOLD;
            Ram1WE <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_HOLD: begin
          drive_en <= 1'b0;
          cnt      <= '0;
`ifdef SRAM_WRITE_VERIFY_EN
          state  <= VR_WAIT;
          Ram1OE <= 1'b0;
`else
          state  <= IDLE;
          Ram1EN <= 1'b1;
          ack_q  <= 1'b1;
          busy_q <= 1'b0;
`endif
        end
        RD_WAIT: begin
          if (cnt == RD_LAST) begin
            rdata_q <= Ram1Data;
            state   <= IDLE;
            Ram1OE  <= 1'b1;
            Ram1EN  <= 1'b1;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef SRAM_WRITE_VERIFY_EN
        VR_WAIT: begin
          if (cnt == RD_LAST) begin
            if (Ram1Data != wdata_q) verify_err_q <= 1'b1;
            state  <= IDLE;
            Ram1OE <= 1'b1;
            Ram1EN <= 1'b1;
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        default: begin
          state    <= IDLE;
          drive_en <= 1'b0;
          Ram1OE   <= 1'b1;
          Ram1WE   <= 1'b1;
          Ram1EN   <= 1'b1;
          busy_q   <= 1'b0;
          ack_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_responder.sv
// Scoreboard bench for sram_port_responder: stimulus pushes expected acks,
// a negedge monitor pops and compares them; pin timing is checked per cycle.
module tb_sram_port_responder;
  import sram_pkg::*;

  localparam int WR   = 2;
  localparam int RD   = 2;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam int VCYC = RD;
`else
  localparam int VCYC = 0;
`endif
  localparam int WLAT = 2 + WR + VCYC;
  localparam int RLAT = RD;

  typedef struct {
    int          cyc;
    logic        is_rd;
    logic [15:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  wire  [15:0] ram_data;
  logic [17:0] ram_addr;
  logic        ram_oe, ram_we, ram_en;
  logic [15:0] mem [0:255];
  logic [15:0] sram_q;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sram_port_responder_if ifc ();

  sram_port_responder dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (ifc),
    .Ram1Addr (ram_addr),
    .Ram1Data (ram_data),
    .Ram1OE   (ram_oe),
    .Ram1WE   (ram_we),
    .Ram1EN   (ram_en)
  );

  // SRAM model: reads when enabled with OE low, captures on the WE rising edge.
  // A write of 0x00FF is stored as 0x00FE to exercise write verification.
  assign sram_q   = mem[ram_addr[7:0]];
  assign ram_data = (!ram_en && !ram_oe) ? sram_q : 'z;

  always @(posedge ram_we) begin
    if (!ram_en) mem[ram_addr[7:0]] <= (ram_data == 16'h00FF) ? 16'h00FE : ram_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {EN, OE, WE, drive, busy} in cycle k after the accept edge.
  function automatic logic [4:0] exp_pins(input logic w, input int k);
    logic en, oe, we, drv, busy;
    busy = (k < (w ? WLAT : RLAT));
    if (w) begin
      en  = !(k < 2 + WR + VCYC);
      we  = !(k >= 1 && k <= WR);
      drv = (k <= WR + 1);
      oe  = !(VCYC > 0 && k >= WR + 2 && k < WR + 2 + VCYC);
    end else begin
      en  = !(k < RD);
      oe  = !(k < RD);
      we  = 1'b1;
      drv = 1'b0;
    end
    return {en, oe, we, drv, busy};
  endfunction

  always @(negedge CLK) begin
    if (RST && ifc.ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ifc.ack), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.is_rd) check("rdata_at_ack", 32'(ifc.rdata), 32'(mon_e.data));
      end
    end
  end

  task automatic access(input logic w, input logic [17:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input bit hold);
    int          lat;
    exp_t        e;
    logic [4:0]  pins;
    lat = w ? WLAT : RLAT;
    ifc.req   = 1'b1;
    ifc.we    = w;
    ifc.addr  = a;
    ifc.wdata = d;
    e.cyc   = cyc + 1 + lat;
    e.is_rd = !w;
    e.data  = exp_rd;
    sb.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        // Scramble the request while busy; the responder must ignore it.
        ifc.req   = hold;
        ifc.we    = ~w;
        ifc.addr  = ~a;
        ifc.wdata = ~d;
      end
      pins = exp_pins(w, k);
      check(w ? "wr_pins" : "rd_pins",
            32'({ram_en, ram_oe, ram_we, dut.drive_en, ifc.busy}), 32'(pins));
      if (pins[1]) check("wr_bus", 32'(ram_data), 32'(d));
      if (!pins[4]) check("addr_pins", 32'(ram_addr), 32'(a));
    end
  endtask

  initial begin
    ifc.req   = 1'b0;
    ifc.we    = 1'b0;
    ifc.addr  = '0;
    ifc.wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;

    repeat (3) @(negedge CLK);
    check("rst_pins", 32'({ram_en, ram_oe, ram_we, dut.drive_en, ifc.busy}), 32'(5'b11100));
    check("rst_ack", 32'(ifc.ack), 32'd0);
    check("rst_rdata", 32'(ifc.rdata), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_verr", 32'(ifc.verify_err), 32'd0);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_no_ack", 32'({ifc.ack, ifc.busy, ram_en}), 32'(3'b001));
    end

    access(1'b1, 18'h00010, 16'hA5A5, 16'h0, 1'b0);
    repeat (2) @(negedge CLK);
    check("mem_a5a5", 32'(mem[8'h10]), 32'h0000_A5A5);

    mem[8'h10] = 16'h1234;
    access(1'b0, 18'h00010, 16'h0, 16'h1234, 1'b0);
    repeat (3) @(negedge CLK);
    check("rdata_held", 32'(ifc.rdata), 32'h1234);

    access(1'b1, 18'h3FFFF, 16'h5A0F, 16'h0, 1'b0);
    repeat (2) @(negedge CLK);
    check("mem_top_addr", 32'(mem[8'hFF]), 32'h5A0F);
    check("rdata_after_wr", 32'(ifc.rdata), 32'h1234);

    access(1'b1, 18'h00003, 16'hBEEF, 16'h0, 1'b1);
    access(1'b0, 18'h00003, 16'h0, 16'hBEEF, 1'b0);
    repeat (2) @(negedge CLK);
    check("b2b_rdata", 32'(ifc.rdata), 32'hBEEF);

    access(1'b0, 18'h3FFFF, 16'h0, 16'h5A0F, 1'b0);
    repeat (2) @(negedge CLK);

    // Abort a write in the middle of the WE pulse.
    ifc.req = 1'b1; ifc.we = 1'b1; ifc.addr = 18'h00040; ifc.wdata = 16'h7777;
    @(negedge CLK);
    ifc.req = 1'b0;
    @(negedge CLK);
    check("pre_abort_we", 32'(ram_we), 32'd0);
    #2 RST = 1'b0;
    #1;
    check("abort_pins", 32'({ram_en, ram_oe, ram_we, dut.drive_en, ifc.busy}), 32'(5'b11100));
    check("abort_ack", 32'(ifc.ack), 32'd0);
    check("abort_rdata", 32'(ifc.rdata), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("no_ack_after_abort", 32'({ifc.ack, ifc.busy}), 32'd0);
    end

`ifdef SRAM_WRITE_VERIFY_EN
    access(1'b1, 18'h00020, 16'h00FF, 16'h0, 1'b0);
    check("verr_set", 32'(ifc.verify_err), 32'd1);
    check("verify_no_rdata", 32'(ifc.rdata), 32'd0);
    repeat (2) @(negedge CLK);
    access(1'b1, 18'h00021, 16'h1111, 16'h0, 1'b0);
    repeat (2) @(negedge CLK);
    check("verr_sticky", 32'(ifc.verify_err), 32'd1);
    check("mem_good_wr", 32'(mem[8'h21]), 32'h1111);
`else
    access(1'b1, 18'h00021, 16'h1111, 16'h0, 1'b0);
    repeat (2) @(negedge CLK);
    check("verr_tied_low", 32'(ifc.verify_err), 32'd0);
    check("mem_good_wr", 32'(mem[8'h21]), 32'h1111);
`endif

    repeat (3) @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
